ram_sync: RTL and testbench

RAM_SYNC -- requirements
Module: ram_sync

---
 rtl/ram_sync_if.sv | 39 +++
 rtl/ram_sync.sv | 120 ++++++++++++
 tb/tb_ram_sync.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_sync_if.sv
// ============================================================================
// ram_sync_if : instruction-read and data-read/write bus of ram_sync
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface ram_sync_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  logic                      i_req;
  logic [ADDR_WIDTH-1:0]     i_address;
  logic                      i_valid;
  logic [DATA_WIDTH-1:0]     i_read_data;

  logic                      d_req;
  logic                      d_wEn;
  logic [DATA_WIDTH/8-1:0]   d_byte_en;
  logic [ADDR_WIDTH-1:0]     d_address;
  logic [DATA_WIDTH-1:0]     d_write_data;
  logic                      d_valid;
  logic [DATA_WIDTH-1:0]     d_read_data;

  modport master (
    output i_req, i_address,
    input  i_valid, i_read_data,
    output d_req, d_wEn, d_byte_en, d_address, d_write_data,
    input  d_valid, d_read_data
  );

  modport slave (
    input  i_req, i_address,
    output i_valid, i_read_data,
    input  d_req, d_wEn, d_byte_en, d_address, d_write_data,
    output d_valid, d_read_data
  );
endinterface

`default_nettype wire

// File: rtl/ram_sync.sv
// ============================================================================
// ram_sync : dual-port synchronous RAM, instruction read port + byte-enabled
//            data read/write port, 1 or 2 cycle read latency
// Revision : 1.0
// ============================================================================
`default_nettype none

module ram_sync #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int READ_LATENCY = 1,
  parameter int FORWARD      = 1
) (
  input  wire logic  clock,
  input  wire logic  reset,
  ram_sync_if.slave  bus
);
  localparam int c_bytes = DATA_WIDTH / 8;
  localparam int c_depth = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [c_depth];

  logic                  w_wr;
  logic                  w_d_rd;
  logic                  w_i_rd;
  logic                  w_collide;
  logic [DATA_WIDTH-1:0] w_i_old;
  logic [DATA_WIDTH-1:0] w_d_old;
  logic [DATA_WIDTH-1:0] w_merged;
  logic [DATA_WIDTH-1:0] w_i_word;

  assign w_wr    = bus.d_req & bus.d_wEn;
  assign w_d_rd  = bus.d_req & ~bus.d_wEn;
  assign w_i_rd  = bus.i_req;
  assign w_i_old = mem[bus.i_address];
  assign w_d_old = mem[bus.d_address];

  always_comb begin
    w_merged = w_d_old;
    for (int k = 0; k < c_bytes; k++) begin
      if (bus.d_byte_en[k]) begin
        w_merged[8*k +: 8] = bus.d_write_data[8*k +: 8];
      end
    end
  end

  // A same-cycle write to the instruction address is visible only when forwarding.
  assign w_collide = (FORWARD != 0) && w_wr && (bus.i_address == bus.d_address);
  assign w_i_word  = w_collide ? w_merged : w_i_old;

  // The array is never cleared; reset only blocks writes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
    end else if (w_wr) begin
      mem[bus.d_address] <= w_merged;
    end
  end

  logic                  r_i_v1;
  logic                  r_d_v1;
  logic [DATA_WIDTH-1:0] r_i_d1;
  logic [DATA_WIDTH-1:0] r_d_d1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_i_v1 <= 1'b0;
      r_d_v1 <= 1'b0;
      r_i_d1 <= '0;
      r_d_d1 <= '0;
    end else begin
      r_i_v1 <= w_i_rd;
      r_d_v1 <= w_d_rd;
      if (w_i_rd) begin
        r_i_d1 <= w_i_word;
      end
      if (w_d_rd) begin
        r_d_d1 <= w_d_old;
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  r_i_v2;
      logic                  r_d_v2;
      logic [DATA_WIDTH-1:0] r_i_d2;
      logic [DATA_WIDTH-1:0] r_d_d2;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_i_v2 <= 1'b0;
          r_d_v2 <= 1'b0;
          r_i_d2 <= '0;
          r_d_d2 <= '0;
        end else begin
          r_i_v2 <= r_i_v1;
          r_d_v2 <= r_d_v1;
          if (r_i_v1) begin
            r_i_d2 <= r_i_d1;
          end
          if (r_d_v1) begin
            r_d_d2 <= r_d_d1;
          end
        end
      end

      assign bus.i_valid     = r_i_v2;
      assign bus.i_read_data = r_i_d2;
      assign bus.d_valid     = r_d_v2;
      assign bus.d_read_data = r_d_d2;
    end else begin : g_lat1
      assign bus.i_valid     = r_i_v1;
      assign bus.i_read_data = r_i_d1;
      assign bus.d_valid     = r_d_v1;
      assign bus.d_read_data = r_d_d1;
    end
  endgenerate
endmodule

`default_nettype wire

// File: tb/tb_ram_sync.sv
// ============================================================================
// tb_ram_sync : checks a latency-1/forwarding and a latency-2/no-forwarding
//               ram_sync against constant vectors and a word-level model
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_ram_sync;
  logic clock;
  logic reset;

  ram_sync_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus1 ();
  ram_sync_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus2 ();

  ram_sync #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .READ_LATENCY(1), .FORWARD(1)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1));
  ram_sync #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .READ_LATENCY(2), .FORWARD(0)) dut2 (
    .clock(clock), .reset(reset), .bus(bus2));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(bit dreq, bit dwen, logic [3:0] be, logic [15:0] da,
                       logic [31:0] wd, bit ireq, logic [15:0] ia);
    bus1.d_req = dreq; bus1.d_wEn = dwen; bus1.d_byte_en = be;
    bus1.d_address = da; bus1.d_write_data = wd;
    bus1.i_req = ireq; bus1.i_address = ia;
    bus2.d_req = dreq; bus2.d_wEn = dwen; bus2.d_byte_en = be;
    bus2.d_address = da; bus2.d_write_data = wd;
    bus2.i_req = ireq; bus2.i_address = ia;
  endtask

  task automatic idle();
    drive(0, 0, 4'h0, 16'h0, 32'h0, 0, 16'h0);
  endtask

  // Reference model: word memory plus a list of results due at a given edge.
  typedef struct {
    int          due;
    int          inst;
    int          port;
    logic [31:0] data;
    bit          known;
  } pend_t;

  logic [31:0] mmem   [int];
  bit          mknown [int];
  pend_t       pq [$];
  int          edge_n = 0;
  bit          exp_v [2][2];
  logic [31:0] exp_d [2][2];
  bit          exp_k [2][2];

  function automatic int lat(int n);
    return (n == 0) ? 1 : 2;
  endfunction

  function automatic bit fwd(int n);
    return (n == 0);
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = wd[8*k +: 8];
    return r;
  endfunction

  task automatic read_word(int a, output logic [31:0] w, output bit k);
    if (mmem.exists(a)) begin w = mmem[a]; k = mknown[a]; end
    else begin w = 32'h0; k = 1'b0; end
  endtask

  task automatic model_reset();
    pq.delete();
    for (int n = 0; n < 2; n++)
      for (int p = 0; p < 2; p++) begin
        exp_v[n][p] = 1'b0; exp_d[n][p] = 32'h0; exp_k[n][p] = 1'b1;
      end
  endtask

  task automatic model_step();
    logic [31:0] w;
    bit          k;
    bit          wr;
    int          ia, da;
    pend_t       p;
    edge_n++;
    if (!reset) begin
      ia = int'(bus1.i_address);
      da = int'(bus1.d_address);
      wr = bus1.d_req && bus1.d_wEn;
      if (bus1.i_req) begin
        read_word(ia, w, k);
        for (int n = 0; n < 2; n++) begin
          p.due = edge_n + lat(n) - 1; p.inst = n; p.port = 0;
          p.data = w; p.known = k;
          if (fwd(n) && wr && ia == da) begin
            p.data  = merge(w, bus1.d_write_data, bus1.d_byte_en);
            p.known = k || (bus1.d_byte_en == 4'hF);
          end
          pq.push_back(p);
        end
      end
      if (bus1.d_req && !bus1.d_wEn) begin
        read_word(da, w, k);
        for (int n = 0; n < 2; n++) begin
          p.due = edge_n + lat(n) - 1; p.inst = n; p.port = 1;
          p.data = w; p.known = k;
          pq.push_back(p);
        end
      end
      if (wr) begin
        read_word(da, w, k);
        mmem[da]   = merge(w, bus1.d_write_data, bus1.d_byte_en);
        mknown[da] = k || (bus1.d_byte_en == 4'hF);
      end
    end
    for (int n = 0; n < 2; n++)
      for (int q = 0; q < 2; q++) exp_v[n][q] = 1'b0;
    for (int j = pq.size() - 1; j >= 0; j--) begin
      if (pq[j].due == edge_n) begin
        exp_v[pq[j].inst][pq[j].port] = 1'b1;
        exp_d[pq[j].inst][pq[j].port] = pq[j].data;
        exp_k[pq[j].inst][pq[j].port] = pq[j].known;
        pq.delete(j);
      end
    end
  endtask

  function automatic logic get_v(int n, int p);
    if (n == 0) return (p == 0) ? bus1.i_valid : bus1.d_valid;
    return (p == 0) ? bus2.i_valid : bus2.d_valid;
  endfunction

  function automatic logic [31:0] get_d(int n, int p);
    if (n == 0) return (p == 0) ? bus1.i_read_data : bus1.d_read_data;
    return (p == 0) ? bus2.i_read_data : bus2.d_read_data;
  endfunction

  task automatic check_all();
    string pn;
    for (int n = 0; n < 2; n++)
      for (int p = 0; p < 2; p++) begin
        pn = (p == 0) ? "i" : "d";
        cmp($sformatf("model dut%0d.%s_valid", n + 1, pn), 32'(get_v(n, p)), 32'(exp_v[n][p]));
        if (exp_k[n][p])
          cmp($sformatf("model dut%0d.%s_read_data", n + 1, pn), get_d(n, p), exp_d[n][p]);
      end
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    #1;
    check_all();
  endtask

  typedef struct {
    bit          dreq;
    bit          dwen;
    logic [3:0]  be;
    logic [15:0] da;
    logic [31:0] wd;
    bit          ireq;
    logic [15:0] ia;
    bit          edv;
    logic [31:0] edd;
    bit          eiv;
    logic [31:0] eid;
  } vec_t;

  vec_t        tbl [17];
  logic [15:0] pool [8];
  bit          r_dreq, r_dwen, r_ireq;
  logic [3:0]  r_be;
  logic [31:0] r_wd;
  logic [15:0] r_da, r_ia;

  initial begin
    // Expected values are for dut1 (latency 1, forwarding), seen right after the edge.
    tbl[0]  = '{1, 1, 4'hF, 16'h0010, 32'hDEADBEEF, 0, 16'h0000, 0, 32'h00000000, 0, 32'h00000000};
    tbl[1]  = '{1, 0, 4'h0, 16'h0010, 32'h00000000, 0, 16'h0000, 1, 32'hDEADBEEF, 0, 32'h00000000};
    tbl[2]  = '{1, 1, 4'hF, 16'h0020, 32'h11223344, 0, 16'h0000, 0, 32'hDEADBEEF, 0, 32'h00000000};
    tbl[3]  = '{1, 1, 4'h5, 16'h0020, 32'hAABBCCDD, 0, 16'h0000, 0, 32'hDEADBEEF, 0, 32'h00000000};
    tbl[4]  = '{1, 0, 4'h0, 16'h0020, 32'h00000000, 0, 16'h0000, 1, 32'h11BB33DD, 0, 32'h00000000};
    tbl[5]  = '{1, 1, 4'hF, 16'h0030, 32'h00000000, 0, 16'h0000, 0, 32'h11BB33DD, 0, 32'h00000000};
    tbl[6]  = '{1, 1, 4'hF, 16'h0030, 32'h12345678, 1, 16'h0030, 0, 32'h11BB33DD, 1, 32'h12345678};
    tbl[7]  = '{1, 0, 4'h0, 16'h0030, 32'h00000000, 1, 16'h0030, 1, 32'h12345678, 1, 32'h12345678};
    tbl[8]  = '{1, 1, 4'hF, 16'hFFFF, 32'h5A5A5A5A, 0, 16'h0000, 0, 32'h12345678, 0, 32'h12345678};
    tbl[9]  = '{1, 0, 4'h0, 16'hFFFF, 32'h00000000, 0, 16'h0000, 1, 32'h5A5A5A5A, 0, 32'h12345678};
    tbl[10] = '{1, 1, 4'h0, 16'hFFFF, 32'hFFFFFFFF, 0, 16'h0000, 0, 32'h5A5A5A5A, 0, 32'h12345678};
    tbl[11] = '{0, 0, 4'h0, 16'h0000, 32'h00000000, 1, 16'hFFFF, 0, 32'h5A5A5A5A, 1, 32'h5A5A5A5A};
    tbl[12] = '{0, 1, 4'hF, 16'h0010, 32'h00000000, 0, 16'h0000, 0, 32'h5A5A5A5A, 0, 32'h5A5A5A5A};
    tbl[13] = '{0, 0, 4'h0, 16'h0000, 32'h00000000, 1, 16'h0010, 0, 32'h5A5A5A5A, 1, 32'hDEADBEEF};
    tbl[14] = '{1, 1, 4'hF, 16'h7FFF, 32'h01020304, 0, 16'h0000, 0, 32'h5A5A5A5A, 0, 32'hDEADBEEF};
    tbl[15] = '{1, 0, 4'h0, 16'h0010, 32'h00000000, 1, 16'h7FFF, 1, 32'hDEADBEEF, 1, 32'h01020304};
    tbl[16] = '{1, 0, 4'h0, 16'hFFFF, 32'h00000000, 0, 16'h0000, 1, 32'h5A5A5A5A, 0, 32'h01020304};
    pool = '{16'h0000, 16'h0001, 16'h0002, 16'h0010, 16'h0030, 16'h7FFF, 16'hFFFE, 16'hFFFF};

    reset = 1'b0;
    idle();
    #2;
    reset = 1'b1;
    model_reset();
    cycle();
    cycle();
    cmp("reset dut1.d_valid", 32'(bus1.d_valid), 32'h0);
    cmp("reset dut2.i_read_data", bus2.i_read_data, 32'h0);
    reset = 1'b0;

    for (int r = 0; r < 17; r++) begin
      drive(tbl[r].dreq, tbl[r].dwen, tbl[r].be, tbl[r].da, tbl[r].wd, tbl[r].ireq, tbl[r].ia);
      cycle();
      cmp($sformatf("row%0d d_valid", r), 32'(bus1.d_valid), 32'(tbl[r].edv));
      cmp($sformatf("row%0d d_read_data", r), bus1.d_read_data, tbl[r].edd);
      cmp($sformatf("row%0d i_valid", r), 32'(bus1.i_valid), 32'(tbl[r].eiv));
      cmp($sformatf("row%0d i_read_data", r), bus1.i_read_data, tbl[r].eid);
    end

    // Idle hold after the 0x5A5A5A5A read.
    idle();
    for (int c = 0; c < 10; c++) begin
      cycle();
      cmp("idle dut1.d_valid", 32'(bus1.d_valid), 32'h0);
      cmp("idle dut1.d_read_data", bus1.d_read_data, 32'h5A5A5A5A);
    end

    // Collision without forwarding on dut2.
    drive(1, 1, 4'hF, 16'h0040, 32'h00000000, 0, 16'h0000);
    cycle();
    drive(1, 1, 4'hF, 16'h0040, 32'h12345678, 1, 16'h0040);
    cycle();
    cmp("coll dut1.i_read_data", bus1.i_read_data, 32'h12345678);
    cmp("coll dut2.i_valid early", 32'(bus2.i_valid), 32'h0);
    idle();
    cycle();
    cmp("coll dut2.i_valid", 32'(bus2.i_valid), 32'h1);
    cmp("coll dut2.i_read_data", bus2.i_read_data, 32'h00000000);

    // Latency-2 back-to-back reads including the top address.
    drive(1, 1, 4'hF, 16'h0000, 32'h0000000A, 0, 16'h0000); cycle();
    drive(1, 1, 4'hF, 16'h0001, 32'h0000000B, 0, 16'h0000); cycle();
    drive(1, 1, 4'hF, 16'hFFFF, 32'h0000000C, 0, 16'h0000); cycle();
    drive(1, 0, 4'h0, 16'h0000, 32'h0, 0, 16'h0000); cycle();
    cmp("lat2 first edge d_valid", 32'(bus2.d_valid), 32'h0);
    drive(1, 0, 4'h0, 16'h0001, 32'h0, 0, 16'h0000); cycle();
    cmp("lat2 d_valid 0", 32'(bus2.d_valid), 32'h1);
    cmp("lat2 data 0", bus2.d_read_data, 32'h0000000A);
    drive(1, 0, 4'h0, 16'hFFFF, 32'h0, 0, 16'h0000); cycle();
    cmp("lat2 d_valid 1", 32'(bus2.d_valid), 32'h1);
    cmp("lat2 data 1", bus2.d_read_data, 32'h0000000B);
    idle(); cycle();
    cmp("lat2 d_valid 2", 32'(bus2.d_valid), 32'h1);
    cmp("lat2 data 2", bus2.d_read_data, 32'h0000000C);
    cycle();
    cmp("lat2 d_valid end", 32'(bus2.d_valid), 32'h0);
    cmp("lat2 data held", bus2.d_read_data, 32'h0000000C);

    // Reset while an instruction read is in flight.
    drive(0, 0, 4'h0, 16'h0000, 32'h0, 1, 16'h0010);
    cycle();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    cmp("rst async dut1.i_valid", 32'(bus1.i_valid), 32'h0);
    cmp("rst async dut1.i_read_data", bus1.i_read_data, 32'h0);
    cmp("rst async dut2.i_read_data", bus2.i_read_data, 32'h0);
    drive(1, 1, 4'hF, 16'h0010, 32'h0BADBEEF, 1, 16'h0010);
    cycle();
    cmp("rst held dut2.i_valid", 32'(bus2.i_valid), 32'h0);
    reset = 1'b0;
    idle();
    cycle();
    cmp("rst post dut1.i_valid", 32'(bus1.i_valid), 32'h0);
    cmp("rst post dut2.i_valid", 32'(bus2.i_valid), 32'h0);
    cmp("rst post dut2.i_read_data", bus2.i_read_data, 32'h0);
    drive(0, 0, 4'h0, 16'h0000, 32'h0, 1, 16'h0010);
    cycle();
    cmp("rst reread dut1.i_read_data", bus1.i_read_data, 32'hDEADBEEF);
    idle();
    cycle();
    cmp("rst reread dut2.i_valid", 32'(bus2.i_valid), 32'h1);
    cmp("rst reread dut2.i_read_data", bus2.i_read_data, 32'hDEADBEEF);

    // Randomized traffic on a small address pool so collisions are frequent.
    for (int c = 0; c < 400; c++) begin
      r_dreq = ($urandom_range(0, 3) != 0);
      r_dwen = $urandom_range(0, 1) != 0;
      r_be   = 4'($urandom_range(0, 15));
      r_wd   = $urandom;
      r_da   = pool[$urandom_range(0, 7)];
      r_ireq = $urandom_range(0, 1) != 0;
      r_ia   = pool[$urandom_range(0, 7)];
      drive(r_dreq, r_dwen, r_be, r_da, r_wd, r_ireq, r_ia);
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
      end else begin
        reset = 1'b0;
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
